yaw_integrator: RTL

//  Consumes the signed 16-bit Z-gyro yaw-rate samples and the single-cycle vld strobe

---
 rtl/yaw_integrator.sv | 118 +++++++++++
 1 files changed

// File: rtl/yaw_integrator.sv
// Gyro yaw integrator: zero-rate offset calibration followed by
// 27-bit heading accumulation with optional IR fusion correction.
module yaw_integrator #(
  parameter int FAST_SIM  = 1,
  parameter int FUS_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cal,
  input  logic        vld,
  input  logic [15:0] yaw_rt,
  input  logic        moving,
  input  logic        en_fusion,
  input  logic [8:0]  IR_Dtrm,
  output logic        cal_done,
  output logic        rdy,
  output logic [11:0] heading
);

  localparam int CAL_SHIFT = (FAST_SIM != 0) ? 8 : 11;
  localparam logic [11:0] CAL_LAST = 12'((1 << CAL_SHIFT) - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAL,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        yaw_off_q, yaw_off_d;
  logic signed [26:0] cal_acc_q, cal_acc_d;
  logic [11:0]        cal_cnt_q, cal_cnt_d;
  logic signed [26:0] heading_int_q, heading_int_d;
  logic               cal_done_q, cal_done_d;
  logic               rdy_q, rdy_d;

  logic signed [26:0] yaw_sext;
  logic signed [26:0] cal_sum;
  logic signed [26:0] cal_avg;
  logic signed [16:0] yaw_comp;
  logic signed [26:0] yaw_term;
  logic signed [26:0] fus_term;

  always_comb begin
    yaw_sext = {{11{yaw_rt[15]}}, yaw_rt};
    cal_sum  = cal_acc_q + yaw_sext;
    cal_avg  = cal_sum >>> CAL_SHIFT;
    yaw_comp = {yaw_rt[15], yaw_rt} - {yaw_off_q[15], yaw_off_q};
    yaw_term = {{10{yaw_comp[16]}}, yaw_comp};
    fus_term = {{18{IR_Dtrm[8]}}, IR_Dtrm} <<< FUS_SHIFT;
  end

  always_comb begin
    state_d       = state_q;
    yaw_off_d     = yaw_off_q;
    cal_acc_d     = cal_acc_q;
    cal_cnt_d     = cal_cnt_q;
    heading_int_d = heading_int_q;
    cal_done_d    = 1'b0;
    rdy_d         = 1'b0;
    // strt_cal outranks a coincident vld: that sample is dropped
    if (strt_cal) begin
      state_d       = CAL;
      cal_acc_d     = '0;
      cal_cnt_d     = '0;
      heading_int_d = '0;
    end else if (vld) begin
      case (state_q)
        CAL: begin
          if (cal_cnt_q == CAL_LAST) begin
            yaw_off_d  = cal_avg[15:0];
            cal_done_d = 1'b1;
            state_d    = RUN;
          end else begin
            cal_acc_d = cal_sum;
            cal_cnt_d = cal_cnt_q + 12'd1;
          end
        end
        RUN: begin
          rdy_d = 1'b1;
          if (moving) begin
            if (en_fusion) begin
              heading_int_d = heading_int_q + yaw_term + fus_term;
            end else begin
              heading_int_d = heading_int_q + yaw_term;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      yaw_off_q     <= '0;
      cal_acc_q     <= '0;
      cal_cnt_q     <= '0;
      heading_int_q <= '0;
      cal_done_q    <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      yaw_off_q     <= yaw_off_d;
      cal_acc_q     <= cal_acc_d;
      cal_cnt_q     <= cal_cnt_d;
      heading_int_q <= heading_int_d;
      cal_done_q    <= cal_done_d;
      rdy_q         <= rdy_d;
    end
  end

  assign cal_done = cal_done_q;
  assign rdy      = rdy_q;
  assign heading  = heading_int_q[26:15];

endmodule
